// File: rtl/egg_timer_pkg.sv
// Shared state encodings and limits for the egg timer control stage.
package egg_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_ALARM   = 3'd5
    } state_t;

    localparam int SEC_MAX = 59;

endpackage

// File: rtl/egg_timer_ctrl_if.sv
// Key pulses in, time/status out, between the key edge detectors, the timer and the display.
interface egg_timer_ctrl_if;
    logic       key_start;
    logic       key_mode;
    logic       key_inc;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [2:0] state;
    logic       running;
    logic       alarm;
    logic       sec_tick;

    modport master (
        output key_start, key_mode, key_inc,
        input  minutes, seconds, state, running, alarm, sec_tick
    );

    modport slave (
        input  key_start, key_mode, key_inc,
        output minutes, seconds, state, running, alarm, sec_tick
    );
endinterface

// File: rtl/egg_timer_ctrl_tick_gen.sv
// Second prescaler: counts enabled cycles, flags the wrap cycle, clear overrides enable.
module tick_gen #(
    parameter int TICKS = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CW-1:0] count_reg;

    assign tick = enable && !clear && (count_reg == CW'(TICKS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tick ? '0 : count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/egg_timer_ctrl.sv
// Countdown timer FSM: set minutes/seconds, run/pause at one tick per second, timed alarm.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_MIN       = 99,
    parameter int ALARM_SECS    = 10
) (
    input logic             clock,
    input logic             reset_n,
    egg_timer_ctrl_if.slave bus
);
    localparam int ACW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

    state_t         state_reg, state_next;
    logic [6:0]     minutes_reg, minutes_next;
    logic [5:0]     seconds_reg, seconds_next;
    logic [ACW-1:0] alarm_cnt_reg, alarm_cnt_next;
    logic           sec_tick_reg, running_reg, alarm_reg;
    logic           pre_clear, pre_enable, tick;
    logic           time_zero, time_one, any_key;

    tick_gen #(.TICKS(TICKS_PER_SEC)) u_tick_gen (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tick   (tick)
    );

    assign time_zero = (minutes_reg == 7'd0) && (seconds_reg == 6'd0);
    assign time_one  = (minutes_reg == 7'd0) && (seconds_reg == 6'd1);
    assign any_key   = bus.key_start || bus.key_mode || bus.key_inc;

    always_comb begin
        state_next     = state_reg;
        minutes_next   = minutes_reg;
        seconds_next   = seconds_reg;
        alarm_cnt_next = alarm_cnt_reg;
        pre_clear      = 1'b0;
        pre_enable     = 1'b0;
        unique case (state_reg)
            ST_IDLE, ST_SET_MIN, ST_SET_SEC: begin
                if (bus.key_start) begin
                    if (!time_zero) begin
                        state_next = ST_RUN;
                        pre_clear  = 1'b1;
                    end
                end else if (bus.key_mode) begin
                    state_next = (state_reg == ST_IDLE)    ? ST_SET_MIN :
                                 (state_reg == ST_SET_MIN) ? ST_SET_SEC : ST_IDLE;
                end else if (bus.key_inc && state_reg == ST_SET_MIN) begin
                    minutes_next = (minutes_reg == 7'(MAX_MIN)) ? 7'd0 : minutes_reg + 1'b1;
                end else if (bus.key_inc && state_reg == ST_SET_SEC) begin
                    seconds_next = (seconds_reg == 6'(SEC_MAX)) ? 6'd0 : seconds_reg + 1'b1;
                end
            end
            ST_RUN: begin
                pre_enable = 1'b1;
                if (tick) begin
                    if (seconds_reg != 6'd0) begin
                        seconds_next = seconds_reg - 1'b1;
                    end else begin
                        minutes_next = minutes_reg - 1'b1;
                        seconds_next = 6'(SEC_MAX);
                    end
                    // Reaching 00:00 outranks a simultaneous pause request.
                    if (time_one)           state_next = ST_ALARM;
                    else if (bus.key_start) state_next = ST_PAUSE;
                end else if (bus.key_start) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.key_start)     state_next = ST_RUN;
                else if (bus.key_mode) state_next = ST_IDLE;
            end
            ST_ALARM: begin
                pre_enable = 1'b1;
                if (any_key) begin
                    state_next     = ST_IDLE;
                    alarm_cnt_next = '0;
                end else if (tick) begin
                    if (alarm_cnt_reg == ACW'(ALARM_SECS - 1)) begin
                        state_next     = ST_IDLE;
                        alarm_cnt_next = '0;
                    end else begin
                        alarm_cnt_next = alarm_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            minutes_reg   <= '0;
            seconds_reg   <= '0;
            alarm_cnt_reg <= '0;
            sec_tick_reg  <= 1'b0;
            running_reg   <= 1'b0;
            alarm_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            minutes_reg   <= minutes_next;
            seconds_reg   <= seconds_next;
            alarm_cnt_reg <= alarm_cnt_next;
            sec_tick_reg  <= (state_reg == ST_RUN) && tick;
            running_reg   <= (state_next == ST_RUN);
            alarm_reg     <= (state_next == ST_ALARM);
        end
    end

    assign bus.state    = state_reg;
    assign bus.minutes  = minutes_reg;
    assign bus.seconds  = seconds_reg;
    assign bus.running  = running_reg;
    assign bus.alarm    = alarm_reg;
    assign bus.sec_tick = sec_tick_reg;
endmodule
